// File: rtl/edsac_arith_unit.sv
// EDSAC arithmetic unit: accumulator and multiplier register with a start/busy/done
// handshake; multiply runs one multiplier bit per cycle, shifts one position per cycle.
module edsac_arith_unit #(
  parameter int WORD = 35,
  localparam int SHORT = (WORD - 1) / 2,
  localparam int ACC_W = 2 * WORD + 1,
  localparam int SW = $clog2(ACC_W + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             long_mode,
  input  logic [WORD-1:0]  operand,
  input  logic [SW-1:0]    shift_n,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [ACC_W-1:0] acc,
  output logic [WORD-1:0]  rs,
  output logic             acc_neg
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_LDR  = 4'd3;
  localparam logic [3:0] OP_MAC  = 4'd4;
  localparam logic [3:0] OP_MNS  = 4'd5;
  localparam logic [3:0] OP_COLL = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_RND  = 4'd9;
  localparam logic [3:0] OP_CLR  = 4'd10;

  localparam logic [SW-1:0]    SHIFT_MAX = SW'(ACC_W);
  localparam logic [SW-1:0]    MUL_LAST  = SW'(WORD - 1);
  localparam logic [SW-1:0]    CNT_ZERO  = SW'(0);
  localparam logic [SW-1:0]    CNT_ONE   = SW'(1);
  localparam logic [ACC_W-1:0] ACC_ZERO  = {ACC_W{1'b0}};
  localparam logic [ACC_W-1:0] RND_INC   = {{(ACC_W-WORD-1){1'b0}}, 1'b1, {WORD{1'b0}}};

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WORD-1:0]  rs_q, rs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
  logic [3:0]       op_q, op_d;
  logic [ACC_W-1:0] mcand_q, mcand_d;
  logic [ACC_W-1:0] prod_q, prod_d;
  logic [WORD-1:0]  mplier_q, mplier_d;
  logic [SW-1:0]    cnt_q, cnt_d;

  logic [SHORT-1:0] short_s;
  logic [WORD-1:0]  mcand_in_s;
  logic [ACC_W-1:0] aligned_s;
  logic [ACC_W-1:0] coll_s;
  logic [ACC_W-1:0] mcand_ext_s;
  logic [ACC_W-1:0] term_s;
  logic [ACC_W-1:0] mul_sum_s;
  logic [ACC_W-1:0] shr1_s;
  logic [ACC_W-1:0] shl1_s;
  logic [SW-1:0]    shift_cnt_s;

  assign short_s     = operand[SHORT-1:0];
  assign mcand_in_s  = long_mode ? operand : {short_s, {(WORD-SHORT){1'b0}}};
  assign aligned_s   = long_mode ? {operand, {(ACC_W-WORD){1'b0}}}
                                 : {short_s, {(ACC_W-SHORT){1'b0}}};
  assign coll_s      = long_mode ? {operand & rs_q, {(ACC_W-WORD){1'b0}}}
                                 : {short_s & rs_q[WORD-1:WORD-SHORT], {(ACC_W-SHORT){1'b0}}};
  // Multiplicand pre-scaled by 4 so the accumulated product already carries the <<2
  assign mcand_ext_s = {{(ACC_W-WORD){mcand_in_s[WORD-1]}}, mcand_in_s} << 2;
  assign term_s      = mplier_q[0] ? mcand_q : ACC_ZERO;
  // Top multiplier bit has negative weight, so the final step subtracts its term
  assign mul_sum_s   = prod_q - term_s;
  assign shr1_s      = {acc_q[ACC_W-1], acc_q[ACC_W-1:1]};
  assign shl1_s      = {acc_q[ACC_W-2:0], 1'b0};
  assign shift_cnt_s = (shift_n > SHIFT_MAX) ? SHIFT_MAX : shift_n;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    rs_d      = rs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    op_d      = op_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          done_d = 1'b1;
          case (op)
            OP_NOP:  acc_d = acc_q;
            OP_ADD:  acc_d = acc_q + aligned_s;
            OP_SUB:  acc_d = acc_q - aligned_s;
            OP_LDR:  rs_d  = mcand_in_s;
            OP_COLL: acc_d = acc_q + coll_s;
            OP_RND:  acc_d = acc_q + RND_INC;
            OP_CLR:  acc_d = ACC_ZERO;
            OP_MAC, OP_MNS: begin
              done_d   = 1'b0;
              busy_d   = 1'b1;
              state_d  = EXEC;
              mcand_d  = mcand_ext_s;
              prod_d   = ACC_ZERO;
              mplier_d = rs_q;
              cnt_d    = CNT_ZERO;
            end
            OP_SHR, OP_SHL: begin
              if (shift_cnt_s != CNT_ZERO) begin
                acc_d = (op == OP_SHR) ? shr1_s : shl1_s;
              end else begin
                acc_d = acc_q;
              end
              // Counts above one keep stepping, one position per cycle
              if (shift_cnt_s > CNT_ONE) begin
                done_d  = 1'b0;
                busy_d  = 1'b1;
                state_d = EXEC;
                cnt_d   = shift_cnt_s - CNT_ONE;
              end else begin
                cnt_d = cnt_q;
              end
            end
            default: illegal_d = 1'b1;
          endcase
        end else begin
          op_d = op_q;
        end
      end
      EXEC: begin
        if ((op_q == OP_MAC) || (op_q == OP_MNS)) begin
          if (cnt_q == MUL_LAST) begin
            acc_d   = (op_q == OP_MNS) ? (acc_q - mul_sum_s) : (acc_q + mul_sum_s);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            prod_d   = prod_q + term_s;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_ONE;
          end
        end else begin
          acc_d = (op_q == OP_SHR) ? shr1_s : shl1_s;
          if (cnt_q == CNT_ONE) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= ACC_ZERO;
      rs_q      <= {WORD{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      op_q      <= OP_NOP;
      mcand_q   <= ACC_ZERO;
      prod_q    <= ACC_ZERO;
      mplier_q  <= {WORD{1'b0}};
      cnt_q     <= CNT_ZERO;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      rs_q      <= rs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      op_q      <= op_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;
  assign acc     = acc_q;
  assign rs      = rs_q;
  assign acc_neg = acc_q[ACC_W-1];

endmodule
